// File: rtl/datapath_seq_pkg.sv
// Shared op-codes, FSM state type and JCN mask bit positions for datapath_seq.
// Imported by the top and the ALU so both decode the same op encoding.
package datapath_seq_pkg;
    localparam logic [3:0] OP_NOP  = 4'd0;
    localparam logic [3:0] OP_LDM  = 4'd1;
    localparam logic [3:0] OP_LD   = 4'd2;
    localparam logic [3:0] OP_XCH  = 4'd3;
    localparam logic [3:0] OP_ADD  = 4'd4;
    localparam logic [3:0] OP_SUB  = 4'd5;
    localparam logic [3:0] OP_INC  = 4'd6;
    localparam logic [3:0] OP_CLB  = 4'd7;
    localparam logic [3:0] OP_RAL  = 4'd8;
    localparam logic [3:0] OP_RAR  = 4'd9;
    localparam logic [3:0] OP_FIM  = 4'd10;
    localparam logic [3:0] OP_ISZ  = 4'd11;
    localparam logic [3:0] OP_JCN  = 4'd12;
    localparam logic [3:0] OP_PINC = 4'd13;

    typedef enum logic {
        IDLE  = 1'b0,
        PAIR2 = 1'b1
    } state_t;

    localparam int JCN_TEST   = 0;
    localparam int JCN_CARRY  = 1;
    localparam int JCN_ZERO   = 2;
    localparam int JCN_INVERT = 3;
endpackage

// File: rtl/datapath_seq_alu.sv
// Combinational ALU: add/subtract with carry, rotate through carry, increment.
// Ops it does not decode pass a through and return cin as the carry-out.
module alu_seq
    import datapath_seq_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic [3:0]       op,
    output logic [WIDTH-1:0] result,
    output logic             cout
);
    always_comb begin
        {cout, result} = {cin, a};
        case (op)
            OP_ADD:  {cout, result} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
            // carry=1 means no borrow, so the incoming carry is inverted too
            OP_SUB:  {cout, result} = {1'b0, a} + {1'b0, ~b} + {{WIDTH{1'b0}}, ~cin};
            OP_RAL:  {cout, result} = {a, cin};
            OP_RAR:  {result, cout} = {cin, a};
            OP_INC:  {cout, result} = {1'b0, a} + {{WIDTH{1'b0}}, 1'b1};
            default: ;
        endcase
    end
endmodule

// File: rtl/datapath_seq.sv
// Accumulator datapath with register file; one micro-op per valid/ready accept.
// FIM and PINC take a second edge in PAIR2, during which op_ready is low.
module datapath_seq
    import datapath_seq_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int NREGS = 16,
    parameter int RIDX  = $clog2(NREGS)
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             halt,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] operand,
    input  logic [WIDTH-1:0] data,
    input  logic             test,
    output logic [WIDTH-1:0] acc,
    output logic             carry,
    output logic [WIDTH-1:0] regval,
    output logic             busy,
    output logic             branch_valid,
    output logic             branch_taken
);
    logic [WIDTH-1:0] regs [NREGS];
    state_t           state;
    logic             pc;
    logic             pair_is_fim;
    logic [RIDX-1:0]  pair_hi;

    logic [RIDX-1:0]  r_idx;
    logic [RIDX-1:0]  hi_idx;
    logic [RIDX-1:0]  lo_idx;
    logic             jcn_cond;

    logic [WIDTH-1:0] alu_a;
    logic [WIDTH-1:0] alu_b;
    logic             alu_cin;
    logic [3:0]       alu_op;
    logic [WIDTH-1:0] alu_res;
    logic             alu_cout;

    assign r_idx    = operand[RIDX-1:0];
    assign hi_idx   = r_idx & ~RIDX'(1);
    assign lo_idx   = r_idx | RIDX'(1);
    assign op_ready = !halt && (state == IDLE);
    assign busy     = (state == PAIR2);
    assign regval   = regs[r_idx];

    assign jcn_cond = (operand[JCN_TEST]  & test)
                    | (operand[JCN_CARRY] & carry)
                    | (operand[JCN_ZERO]  & (acc == '0));

    // PAIR2 reuses the adder to propagate the saved low-half carry into hi
    always_comb begin
        alu_a   = acc;
        alu_b   = regs[r_idx];
        alu_cin = carry;
        alu_op  = op;
        if (state == PAIR2) begin
            alu_a   = regs[pair_hi];
            alu_b   = '0;
            alu_cin = pc;
            alu_op  = OP_ADD;
        end else if (op == OP_INC || op == OP_ISZ) begin
            alu_a  = regs[r_idx];
            alu_op = OP_INC;
        end else if (op == OP_PINC) begin
            alu_a  = regs[lo_idx];
            alu_op = OP_INC;
        end
    end

    alu_seq #(.WIDTH(WIDTH)) u_alu (
        .a      (alu_a),
        .b      (alu_b),
        .cin    (alu_cin),
        .op     (alu_op),
        .result (alu_res),
        .cout   (alu_cout)
    );

    // Register file is deliberately not reset; it only gates writes on reset.
    always_ff @(posedge clock) begin
        if (!reset && !halt) begin
            if (state == PAIR2) begin
                if (pair_is_fim) regs[pair_hi | RIDX'(1)] <= data;
                else             regs[pair_hi]            <= alu_res;
            end else if (op_valid) begin
                case (op)
                    OP_XCH:         regs[r_idx]  <= acc;
                    OP_INC, OP_ISZ: regs[r_idx]  <= alu_res;
                    OP_FIM:         regs[hi_idx] <= data;
                    OP_PINC:        regs[lo_idx] <= alu_res;
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= IDLE;
            acc          <= '0;
            carry        <= 1'b0;
            pc           <= 1'b0;
            pair_is_fim  <= 1'b0;
            pair_hi      <= '0;
            branch_valid <= 1'b0;
            branch_taken <= 1'b0;
        end else if (!halt) begin
            branch_valid <= 1'b0;
            if (state == PAIR2) begin
                state <= IDLE;
            end else if (op_valid) begin
                case (op)
                    OP_LDM: acc <= operand;
                    OP_LD,
                    OP_XCH: acc <= regs[r_idx];
                    OP_ADD, OP_SUB, OP_RAL, OP_RAR: begin
                        acc   <= alu_res;
                        carry <= alu_cout;
                    end
                    OP_CLB: begin
                        acc   <= '0;
                        carry <= 1'b0;
                    end
                    OP_ISZ: begin
                        branch_valid <= 1'b1;
                        branch_taken <= (alu_res != '0);
                    end
                    OP_JCN: begin
                        branch_valid <= 1'b1;
                        branch_taken <= jcn_cond ^ operand[JCN_INVERT];
                    end
                    OP_FIM: begin
                        state       <= PAIR2;
                        pair_is_fim <= 1'b1;
                        pair_hi     <= hi_idx;
                    end
                    OP_PINC: begin
                        state       <= PAIR2;
                        pair_is_fim <= 1'b0;
                        pair_hi     <= hi_idx;
                        pc          <= alu_cout;
                    end
                    default: ;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_datapath_seq.sv
// Scoreboard bench for datapath_seq: directed scenarios plus random op streams
// checked against an integer-arithmetic reference model.
module tb_datapath_seq;
    import datapath_seq_pkg::*;

    localparam int W = 4;
    localparam int N = 16;

    logic         clock = 1'b0;
    logic         reset, halt, op_valid, test;
    logic         op_ready, carry, busy, branch_valid, branch_taken;
    logic [3:0]   op;
    logic [W-1:0] operand, data, acc, regval;

    datapath_seq #(.WIDTH(W), .NREGS(N)) dut (
        .clock        (clock),
        .reset        (reset),
        .halt         (halt),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op           (op),
        .operand      (operand),
        .data         (data),
        .test         (test),
        .acc          (acc),
        .carry        (carry),
        .regval       (regval),
        .busy         (busy),
        .branch_valid (branch_valid),
        .branch_taken (branch_taken)
    );

    always #5 clock = ~clock;

    typedef struct {
        int acc;
        int carry;
        int busy;
        int bv;
        int bt;
    } exp_t;

    exp_t sbq[$];
    int   checks = 0;
    int   errors = 0;
    int   m_acc, m_carry, m_bt;
    int   m_regs[N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one expected record per accept edge, compared at the following negedge.
    initial begin
        bit   pend;
        exp_t e;
        pend = 1'b0;
        forever begin
            @(negedge clock);
            if (pend) begin
                if (sbq.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_underflow: accept seen with no expected entry at %0t", $time);
                end else begin
                    e = sbq.pop_front();
                    check("sb_acc", 32'(acc), e.acc);
                    check("sb_carry", 32'(carry), e.carry);
                    check("sb_busy", 32'(busy), e.busy);
                    check("sb_bvalid", 32'(branch_valid), e.bv);
                    if (e.bv != 0) check("sb_btaken", 32'(branch_taken), e.bt);
                end
            end
            pend = op_valid && op_ready && !reset;
        end
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Drive one op, update the model, push the expectation; returns #1 after the accept edge.
    task automatic issue(input int o, input int opnd, input int d1, input int d2, input bit tst);
        int   n, r, hi, lo, s, v;
        bit   c;
        exp_t e;
        n = 0;
        while (op_ready !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL ready_timeout: op_ready=%b expected 1 within 20 cycles", op_ready);
        end
        op_valid = 1'b1;
        op       = 4'(o);
        operand  = W'(opnd);
        data     = W'(d1);
        test     = tst;

        r  = opnd % N;
        hi = r & (N - 2);
        lo = r | 1;
        e.bv = 0;
        case (o)
            1: m_acc = opnd;
            2: m_acc = m_regs[r];
            3: begin
                s = m_acc;
                m_acc = m_regs[r];
                m_regs[r] = s;
            end
            4: begin
                s = m_acc + m_regs[r] + m_carry;
                m_acc = s % 16;
                m_carry = (s >= 16);
            end
            5: begin
                s = m_acc + (15 - m_regs[r]) + (1 - m_carry);
                m_acc = s % 16;
                m_carry = (s >= 16);
            end
            6: m_regs[r] = (m_regs[r] + 1) % 16;
            7: begin
                m_acc = 0;
                m_carry = 0;
            end
            8: begin
                s = m_acc * 2 + m_carry;
                m_carry = (m_acc >= 8);
                m_acc = s % 16;
            end
            9: begin
                s = m_carry;
                m_carry = m_acc % 2;
                m_acc = m_acc / 2 + s * 8;
            end
            10: begin
                m_regs[hi] = d1 % 16;
                m_regs[lo] = d2 % 16;
            end
            11: begin
                m_regs[r] = (m_regs[r] + 1) % 16;
                m_bt = (m_regs[r] != 0);
                e.bv = 1;
            end
            12: begin
                c = ((opnd & 1) != 0 && tst) || ((opnd & 2) != 0 && m_carry != 0) ||
                    ((opnd & 4) != 0 && m_acc == 0);
                m_bt = int'(c) ^ ((opnd >> 3) & 1);
                e.bv = 1;
            end
            13: begin
                v = (m_regs[hi] * 16 + m_regs[lo] + 1) % 256;
                m_regs[hi] = v / 16;
                m_regs[lo] = v % 16;
            end
            default: ;
        endcase
        e.acc   = m_acc;
        e.carry = m_carry;
        e.busy  = (o == 10 || o == 13);
        e.bt    = m_bt;
        sbq.push_back(e);

        tick();
        op_valid = 1'b0;
        data     = W'(d2);
        op       = 4'($urandom_range(0, 15));
        operand  = W'($urandom_range(0, 15));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int old_lo;
        reset = 1'b1; halt = 1'b0; op_valid = 1'b0; op = '0;
        operand = '0; data = '0; test = 1'b0;
        m_acc = 0; m_carry = 0; m_bt = 0;
        for (int i = 0; i < N; i++) m_regs[i] = 0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;
        check("rst_acc", 32'(acc), 0);
        check("rst_carry", 32'(carry), 0);
        check("rst_ready", 32'(op_ready), 1);
        check("rst_busy", 32'(busy), 0);
        check("rst_bvalid", 32'(branch_valid), 0);
        check("rst_btaken", 32'(branch_taken), 0);

        for (int p = 0; p < N / 2; p++)
            issue(OP_FIM, 2 * p, $urandom_range(0, 15), (p == 1) ? 8 : $urandom_range(0, 15), 0);

        issue(OP_LDM, 9, 0, 0, 0);
        issue(OP_ADD, 3, 0, 0, 0);
        issue(OP_SUB, 3, 0, 0, 0);

        issue(OP_FIM, 4, 'hA, 5, 0);
        check("fim_ready_low", 32'(op_ready), 0);
        check("fim_busy", 32'(busy), 1);
        tick();
        check("fim_ready_back", 32'(op_ready), 1);
        check("fim_busy_clr", 32'(busy), 0);
        operand = 4; #1 check("fim_hi", 32'(regval), 'hA);
        operand = 5; #1 check("fim_lo", 32'(regval), 5);

        issue(OP_FIM, 6, 'hF, 'hF, 0);
        issue(OP_PINC, 6, 0, 0, 0);
        tick();
        operand = 6; #1 check("pinc_ff_hi", 32'(regval), m_regs[6]);
        operand = 7; #1 check("pinc_ff_lo", 32'(regval), m_regs[7]);
        check("pinc_carry", 32'(carry), m_carry);
        issue(OP_FIM, 8, 3, 'hF, 0);
        issue(OP_PINC, 8, 0, 0, 0);
        tick();
        operand = 8; #1 check("pinc_3f_hi", 32'(regval), m_regs[8]);
        operand = 9; #1 check("pinc_3f_lo", 32'(regval), m_regs[9]);

        issue(OP_CLB, 0, 0, 0, 0);
        issue(OP_JCN, 'b0100, 0, 0, 0);
        tick();
        check("bvalid_fall", 32'(branch_valid), 0);
        issue(OP_JCN, 'b1100, 0, 0, 0);
        issue(OP_FIM, 10, 'hF, 1, 0);
        issue(OP_ISZ, 10, 0, 0, 0);
        tick();
        operand = 10; #1 check("isz_wrap", 32'(regval), m_regs[10]);

        // halt held through PAIR2 of a FIM
        old_lo = m_regs[13];
        issue(OP_FIM, 12, 6, 9, 0);
        halt = 1'b1;
        operand = 13;
        for (int k = 0; k < 3; k++) begin
            data = W'($urandom_range(0, 15));
            tick();
            check("halt_busy", 32'(busy), 1);
            check("halt_ready", 32'(op_ready), 0);
            check("halt_lo_hold", 32'(regval), old_lo);
        end
        data = 9;
        halt = 1'b0;
        tick();
        check("halt_resume_busy", 32'(busy), 0);
        check("halt_resume_lo", 32'(regval), m_regs[13]);

        // reset during PAIR2 of a FIM
        old_lo = m_regs[3];
        issue(OP_FIM, 2, 'hC, 7, 0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_regs[3] = old_lo; m_acc = 0; m_carry = 0; m_bt = 0;
        check("prst_busy", 32'(busy), 0);
        check("prst_ready", 32'(op_ready), 1);
        check("prst_acc", 32'(acc), 0);
        check("prst_carry", 32'(carry), 0);
        operand = 2; #1 check("prst_hi", 32'(regval), m_regs[2]);
        operand = 3; #1 check("prst_lo", 32'(regval), old_lo);
        tick();
        check("prst_lo_later", 32'(regval), old_lo);

        for (int t = 0; t < 400; t++) begin
            if ($urandom_range(0, 3) == 0) tick();
            else issue($urandom_range(0, 15), $urandom_range(0, 15), $urandom_range(0, 15),
                       $urandom_range(0, 15), 1'($urandom_range(0, 1)));
        end
        tick();
        tick();
        for (int i = 0; i < N; i++) begin
            operand = W'(i);
            #1 check("final_reg", 32'(regval), m_regs[i]);
        end
        check("final_acc", 32'(acc), m_acc);
        check("final_carry", 32'(carry), m_carry);
        check("sb_empty", 32'(sbq.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
